lab_1_mealy: RTL and testbench



---
 rtl/lab_1_mealy.sv | 55 +++++
 tb/tb_lab_1_mealy.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lab_1_mealy.sv
// Mealy level-to-pulse converter: tick marks each 0->1 transition of level.
// Define LAB1_FALL_TICK_EN to add fall_tick, which marks each 1->0 transition.
module lab_1_mealy (
   input  logic level,
   input  logic clk,
   output logic tick,
   input  logic rst
`ifdef LAB1_FALL_TICK_EN
   ,
   output logic fall_tick
`endif
);

   // ZERO: level last sampled low; ONE: level last sampled high.
   typedef enum logic {
      ZERO = 1'b0,
      ONE  = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ZERO;
      end else begin
         state <= state_next;
      end
   end

   // The next state is simply the sampled level.
   // The outputs are gated by rst so that they drop the instant reset asserts.
   always_comb begin
      state_next = state;
      tick       = 1'b0;
      case (state)
         ZERO: begin
            if (level) state_next = ONE;
            tick = level & ~rst;
         end
         ONE: begin
            if (!level) state_next = ZERO;
         end
         default: state_next = ZERO;
      endcase
   end

`ifdef LAB1_FALL_TICK_EN
   always_comb begin
      fall_tick = 1'b0;
      if (state == ONE) fall_tick = ~level & ~rst;
   end
`endif

endmodule

// File: tb/tb_lab_1_mealy.sv
// Bench for lab_1_mealy: directed edge cases followed by random level/reset traffic
// checked against a "last sampled level" reference model.
`timescale 1ns/1ps
module tb_lab_1_mealy;

   logic clk;
   logic rst;
   logic level;
   logic tick;
`ifdef LAB1_FALL_TICK_EN
   logic fall_tick;
`endif

   int   checks;
   int   errors;
   logic last_level;   // reference model: level seen at the last posedge, 0 after reset

   lab_1_mealy dut (
      .level(level),
      .clk(clk),
      .tick(tick),
      .rst(rst)
`ifdef LAB1_FALL_TICK_EN
      ,
      .fall_tick(fall_tick)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #1 clk = ~clk;
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_tick();
      return !rst && level && !last_level;
   endfunction

   function automatic logic exp_fall();
      return !rst && !level && last_level;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_tick"}, tick, exp_tick());
      check({tag, "_state"}, logic'(dut.state), last_level);
`ifdef LAB1_FALL_TICK_EN
      check({tag, "_fall"}, fall_tick, exp_fall());
`endif
   endtask

   // Advance through a posedge and update the model the way the spec describes.
   task automatic step_posedge();
      @(posedge clk);
      #0.1;
      last_level = rst ? 1'b0 : level;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      last_level = 1'b0;
      rst        = 1'b1;
      level      = 1'b0;

      // Reset with level low and high.
      #0.5;
      check("rst_l0_tick", tick, 1'b0);
      check("rst_l0_state", logic'(dut.state), 1'b0);
      level = 1'b1;
      #0.2;
      check("rst_l1_tick", tick, 1'b0);
      check("rst_l1_state", logic'(dut.state), 1'b0);
      @(negedge clk);
      level = 1'b0;
      rst   = 1'b0;
      #0.3;
      check_outputs("rel");
      step_posedge();
      check_outputs("rel_post");

      // Rise, then hold for 5 cycles: exactly one tick.
      @(negedge clk);
      level = 1'b1;
      #0.3;
      check("rise_tick", tick, 1'b1);
      check_outputs("rise");
      step_posedge();
      check("rise_state_one", logic'(dut.state), 1'b1);
      check("rise_tick_drop", tick, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #0.3;
         check("hold_tick", tick, 1'b0);
         step_posedge();
      end

      // Glitch while ONE: no tick; next posedge samples 0.
      @(negedge clk);
      #0.1;
      level = 1'b0;
      #0.1;
      check("gone_a", tick, 1'b0);
      #0.1;
      level = 1'b1;
      #0.1;
      check("gone_b", tick, 1'b0);
      #0.1;
      level = 1'b0;
      #0.1;
      check("gone_c", tick, 1'b0);
      step_posedge();
      check("gone_state", logic'(dut.state), 1'b0);
      check_outputs("gone_post");

      // Glitch while ZERO: tick only for the glitch width.
      @(negedge clk);
      #0.2;
      level = 1'b1;
      #0.1;
      check("gzero_tick", tick, 1'b1);
      #0.1;
      level = 1'b0;
      #0.1;
      check("gzero_drop", tick, 1'b0);
      step_posedge();
      check("gzero_state", logic'(dut.state), 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #0.3;
         check("gzero_quiet", tick, 1'b0);
         step_posedge();
      end

      // Async reset with state ONE and level high.
      @(negedge clk);
      level = 1'b1;
      step_posedge();
      check("ar_pre_state", logic'(dut.state), 1'b1);
      @(negedge clk);
      #0.3;
      rst = 1'b1;
      #0.1;
      check("ar_state", logic'(dut.state), 1'b0);
      check("ar_tick", tick, 1'b0);
      last_level = 1'b0;
      step_posedge();
      @(negedge clk);
      rst = 1'b0;
      #0.3;
      check("ar_rel_tick", tick, 1'b1);
      step_posedge();
      check("ar_rel_drop", tick, 1'b0);
      check("ar_rel_state", logic'(dut.state), 1'b1);

`ifdef LAB1_FALL_TICK_EN
      @(negedge clk);
      level = 1'b0;
      #0.3;
      check("fall_tick_hi", fall_tick, 1'b1);
      check("fall_rise_lo", tick, 1'b0);
      step_posedge();
      check("fall_tick_drop", fall_tick, 1'b0);
`endif

      // Random traffic, with occasional mid-cycle async resets.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         level = 1'($urandom_range(0, 1));
         if (rst) rst = 1'($urandom_range(0, 3) == 0);
         #0.3;
         check_outputs("rnd");
         if (!rst && $urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            #0.1;
            last_level = 1'b0;
            check_outputs("rnd_ar");
         end
         step_posedge();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
